// File: rtl/kf_dma_multichannel.sv
// Parametrised multichannel DMA controller: hold handshake, fixed/rotating priority, single/block modes.
// Optional KF_DMA_AUTOINIT_EN adds base registers and autoinitialisation on terminal count.
module kf_dma_multichannel #(
    parameter int CHANNELS      = 4,
    parameter int ADDRESS_WIDTH = 20,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          reg_write,
    input  logic                          reg_read,
    input  logic [$clog2(CHANNELS)+2:0]   reg_address,
    input  logic [31:0]                   reg_data_in,
    output logic [31:0]                   reg_data_out,
    input  logic [CHANNELS-1:0]           dma_request,
    output logic [CHANNELS-1:0]           dma_acknowledge,
    output logic                          hold_request,
    input  logic                          hold_acknowledge,
    input  logic                          ready,
    output logic [ADDRESS_WIDTH-1:0]      address_out,
    output logic                          address_enable,
    output logic                          address_strobe,
    output logic                          memory_read_n,
    output logic                          memory_write_n,
    output logic                          io_read_n,
    output logic                          io_write_n,
    input  logic                          end_of_process_n_in,
    output logic                          end_of_process_n_out
);
    localparam int CW = $clog2(CHANNELS);
    localparam int RW = CW + 3;

    typedef enum logic [2:0] {IDLE, HOLD, S1, S2, S3, S4} state_t;
    state_t state, state_next;

    logic [1:0]               command;
    logic [CHANNELS-1:0]      mask, tc, swreq;
    logic [CW-1:0]            last, winner, pick;
    logic                     pick_valid;
    logic                     eop_seen;
    logic [ADDRESS_WIDTH-1:0] cur_addr [CHANNELS];
    logic [COUNT_WIDTH-1:0]   cur_cnt  [CHANNELS];
    logic [4:0]               mode     [CHANNELS];
`ifdef KF_DMA_AUTOINIT_EN
    logic [ADDRESS_WIDTH-1:0] base_addr [CHANNELS];
    logic [COUNT_WIDTH-1:0]   base_cnt  [CHANNELS];
`endif

    logic          is_global, ch_ok;
    logic [1:0]    reg_sel;
    logic [CW-1:0] reg_ch;
    logic [31:0]   rd_val;
    logic          unused;

    assign is_global = reg_address[RW-1];
    assign reg_sel   = reg_address[1:0];
    assign reg_ch    = reg_address[CW+1:2];
    assign ch_ok     = int'(reg_ch) < CHANNELS;
    assign unused    = ^reg_data_in;

    logic [CHANNELS-1:0] raw_req, eff_req;
    assign raw_req = dma_request | swreq;
    assign eff_req = command[0] ? (raw_req & ~mask) : '0;

    // Scan from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        int idx;
        idx        = 0;
        pick       = '0;
        pick_valid = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            idx = command[1] ? (int'(last) + 1 + i) % CHANNELS : i;
            if (eff_req[idx]) begin
                pick       = CW'(idx);
                pick_valid = 1'b1;
            end
        end
    end

    logic [1:0] xfer_type;
    logic       at_tc, active, strobing;
    assign xfer_type = mode[winner][1:0];
    assign at_tc     = (cur_cnt[winner] == '0) || eop_seen;
    assign active    = (state == S1) || (state == S2) || (state == S3) || (state == S4);
    assign strobing  = (state == S2) || (state == S3);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|eff_req) state_next = HOLD;
            HOLD:    if (hold_acknowledge) state_next = pick_valid ? S1 : IDLE;
            S1:      state_next = S2;
            S2:      state_next = S3;
            S3:      if (ready) state_next = S4;
            S4:      state_next = (mode[winner][4] && !at_tc) ? S1 : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dma_acknowledge = '0;
        if (active) dma_acknowledge[winner] = 1'b1;
    end

    assign hold_request         = (state != IDLE);
    assign address_enable       = active;
    assign address_strobe       = (state == S1);
    assign address_out          = active ? cur_addr[winner] : '0;
    assign io_read_n            = !(strobing && xfer_type == 2'b01);
    assign memory_write_n       = !(strobing && xfer_type == 2'b01);
    assign memory_read_n        = !(strobing && xfer_type == 2'b10);
    assign io_write_n           = !(strobing && xfer_type == 2'b10);
    assign end_of_process_n_out = !(state == S4 && at_tc);

    always_comb begin
        rd_val = '0;
        if (is_global) begin
            case (reg_sel)
                2'd0: rd_val = 32'(command);
                2'd1: rd_val = 32'(mask);
                2'd2: rd_val = 32'({raw_req, tc});
                2'd3: rd_val = 32'(swreq);
                default: rd_val = '0;
            endcase
        end else if (ch_ok) begin
            case (reg_sel)
                2'd0: rd_val = 32'(cur_addr[reg_ch]);
                2'd1: rd_val = 32'(cur_cnt[reg_ch]);
                2'd2: rd_val = 32'(mode[reg_ch]);
                2'd3: rd_val = 32'({tc[reg_ch], cur_cnt[reg_ch]});
                default: rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            command      <= '0;
            mask         <= '1;
            tc           <= '0;
            swreq        <= '0;
            last         <= '0;
            winner       <= '0;
            eop_seen     <= 1'b0;
            reg_data_out <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cur_addr[i] <= '0;
                cur_cnt[i]  <= '0;
                mode[i]     <= '0;
`ifdef KF_DMA_AUTOINIT_EN
                base_addr[i] <= '0;
                base_cnt[i]  <= '0;
`endif
            end
        end else begin
            state <= state_next;
            if (reg_read) reg_data_out <= rd_val;
            if (reg_read && is_global && reg_sel == 2'd2) tc <= '0;

            // Only mask and software request may change while a transfer is in flight.
            if (reg_write && is_global) begin
                case (reg_sel)
                    2'd0: if (state == IDLE) command <= reg_data_in[1:0];
                    2'd1: mask  <= reg_data_in[CHANNELS-1:0];
                    2'd3: swreq <= reg_data_in[CHANNELS-1:0];
                    default: ;
                endcase
            end else if (reg_write && ch_ok && state == IDLE) begin
                case (reg_sel)
                    2'd0: begin
                        cur_addr[reg_ch] <= reg_data_in[ADDRESS_WIDTH-1:0];
`ifdef KF_DMA_AUTOINIT_EN
                        base_addr[reg_ch] <= reg_data_in[ADDRESS_WIDTH-1:0];
`endif
                    end
                    2'd1: begin
                        cur_cnt[reg_ch] <= reg_data_in[COUNT_WIDTH-1:0];
`ifdef KF_DMA_AUTOINIT_EN
                        base_cnt[reg_ch] <= reg_data_in[COUNT_WIDTH-1:0];
`endif
                    end
`ifdef KF_DMA_AUTOINIT_EN
                    2'd2: mode[reg_ch] <= reg_data_in[4:0];
`else
                    2'd2: mode[reg_ch] <= {reg_data_in[4:3], 1'b0, reg_data_in[1:0]};
`endif
                    default: ;
                endcase
            end

            if (state == HOLD && hold_acknowledge && pick_valid) winner <= pick;

            if (state == S1) eop_seen <= 1'b0;
            else if (strobing && !end_of_process_n_in) eop_seen <= 1'b1;

            // Transfer completion comes after register writes so TC updates take precedence.
            if (state == S4) begin
                cur_addr[winner] <= mode[winner][3] ? cur_addr[winner] - 1'b1
                                                    : cur_addr[winner] + 1'b1;
                cur_cnt[winner]  <= cur_cnt[winner] - 1'b1;
                last             <= winner;
                if (at_tc) begin
                    tc[winner]    <= 1'b1;
                    swreq[winner] <= 1'b0;
`ifdef KF_DMA_AUTOINIT_EN
                    if (mode[winner][2]) begin
                        cur_addr[winner] <= base_addr[winner];
                        cur_cnt[winner]  <= base_cnt[winner];
                    end else begin
                        mask[winner] <= 1'b1;
                    end
`else
                    mask[winner] <= 1'b1;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_kf_dma_multichannel.sv
// Scoreboard bench for kf_dma_multichannel: transfer-level reference model feeds expected queues,
// a negedge monitor pops and compares register reads and bus transfers.
module tb_kf_dma_multichannel;
    logic        clock, reset;
    logic        reg_write, reg_read;
    logic [4:0]  reg_address;
    logic [31:0] reg_data_in, reg_data_out;
    logic [3:0]  dma_request, dma_acknowledge;
    logic        hold_request, hold_acknowledge, ready;
    logic [19:0] address_out;
    logic        address_enable, address_strobe;
    logic        memory_read_n, memory_write_n, io_read_n, io_write_n;
    logic        end_of_process_n_in, end_of_process_n_out;

    kf_dma_multichannel dut (
        .clock(clock), .reset(reset), .reg_write(reg_write), .reg_read(reg_read),
        .reg_address(reg_address), .reg_data_in(reg_data_in), .reg_data_out(reg_data_out),
        .dma_request(dma_request), .dma_acknowledge(dma_acknowledge),
        .hold_request(hold_request), .hold_acknowledge(hold_acknowledge), .ready(ready),
        .address_out(address_out), .address_enable(address_enable),
        .address_strobe(address_strobe), .memory_read_n(memory_read_n),
        .memory_write_n(memory_write_n), .io_read_n(io_read_n), .io_write_n(io_write_n),
        .end_of_process_n_in(end_of_process_n_in), .end_of_process_n_out(end_of_process_n_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef KF_DMA_AUTOINIT_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct { int ch; logic [19:0] addr; logic [3:0] pat; int low; bit eop; } xfer_t;
    typedef struct { string name; logic [31:0] val; } rd_t;
    xfer_t exp_q[$];
    rd_t   rd_q[$];

    // Reference model state
    logic [19:0] m_addr[4], m_base_addr[4];
    logic [15:0] m_cnt[4], m_base_cnt[4];
    logic [4:0]  m_mode[4];
    logic [3:0]  m_mask, m_tc, m_sw;
    logic [1:0]  m_cmd;
    int          m_last;

    task automatic model_reset();
        m_cmd = 0; m_mask = 4'hF; m_tc = 0; m_sw = 0; m_last = 0;
        for (int i = 0; i < 4; i++) m_mode[i] = 0;
    endtask

    function automatic int pick(input logic [3:0] eff);
        for (int k = 0; k < 4; k++) begin
            int c;
            c = m_cmd[1] ? (m_last + 1 + k) % 4 : k;
            if (eff[c]) return c;
        end
        return -1;
    endfunction

    // Predict every transfer the controller will perform with the given static DREQ lines.
    task automatic model_run(input logic [3:0] dreq, input int first_low, input bit first_eop);
        bit first;
        logic [3:0] eff;
        int w;
        bit t;
        xfer_t e;
        first = 1;
        for (int guard = 0; guard < 64; guard++) begin
            eff = m_cmd[0] ? ((dreq | m_sw) & ~m_mask) : 4'b0;
            if (eff == 0) break;
            w = pick(eff);
            do begin
                t = (m_cnt[w] == 0) || (first && first_eop);
                e.ch = w; e.addr = m_addr[w]; e.eop = t;
                case (m_mode[w][1:0])
                    2'b01:   e.pat = 4'b0110;
                    2'b10:   e.pat = 4'b1001;
                    default: e.pat = 4'b0000;
                endcase
                e.low = (e.pat == 0) ? 0 : (first ? first_low : 2);
                exp_q.push_back(e);
                first = 0;
                m_addr[w] = m_mode[w][3] ? m_addr[w] - 20'd1 : m_addr[w] + 20'd1;
                m_cnt[w]  = m_cnt[w] - 16'd1;
                m_last    = w;
                if (t) begin
                    m_tc[w] = 1; m_sw[w] = 0;
                    if (AI && m_mode[w][2]) begin
                        m_addr[w] = m_base_addr[w]; m_cnt[w] = m_base_cnt[w];
                    end else m_mask[w] = 1;
                end
            end while (m_mode[w][4] && !t);
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        reg_address = a; reg_data_in = d; reg_write = 1;
        @(negedge clock);
        reg_write = 0;
    endtask

    task automatic bus_read(input logic [4:0] a, input logic [31:0] exp, input string name);
        rd_t r;
        r.name = name; r.val = exp;
        rd_q.push_back(r);
        reg_address = a; reg_read = 1;
        @(negedge clock);
        reg_read = 0;
    endtask

    task automatic wr_ch(input int ch, input int r, input logic [31:0] d);
        logic [1:0] c2, r2;
        c2 = ch[1:0]; r2 = r[1:0];
        bus_write({1'b0, c2, r2}, d);
        case (r)
            0: begin m_addr[ch] = d[19:0]; m_base_addr[ch] = d[19:0]; end
            1: begin m_cnt[ch] = d[15:0]; m_base_cnt[ch] = d[15:0]; end
            2: m_mode[ch] = d[4:0];
            default: ;
        endcase
    endtask

    task automatic wr_gl(input int r, input logic [31:0] d);
        logic [1:0] r2;
        r2 = r[1:0];
        bus_write({3'b100, r2}, d);
        case (r)
            0: m_cmd = d[1:0];
            1: m_mask = d[3:0];
            3: m_sw = d[3:0];
            default: ;
        endcase
    endtask

    task automatic rd_ch(input int ch, input int r, input logic [31:0] exp, input string name);
        logic [1:0] c2, r2;
        c2 = ch[1:0]; r2 = r[1:0];
        bus_read({1'b0, c2, r2}, exp, name);
    endtask

    task automatic rd_gl(input int r, input logic [31:0] exp, input string name);
        logic [1:0] r2;
        r2 = r[1:0];
        bus_read({3'b100, r2}, exp, name);
    endtask

    task automatic rd_status(input string name);
        bus_read(5'b10010, {24'b0, dma_request | m_sw, m_tc}, name);
        m_tc = 0;
    endtask

    task automatic unmask(input int ch);
        logic [3:0] m;
        m = m_mask;
        m[ch] = 1'b0;
        wr_gl(1, {28'b0, m});
    endtask

    // Bus-arbiter model: grant after a random 0..3 cycle delay.
    int ack_dly = 0;
    always @(negedge clock) begin
        if (!hold_request) begin
            hold_acknowledge = 0;
            ack_dly = $urandom_range(0, 3);
        end else if (!hold_acknowledge) begin
            if (ack_dly == 0) hold_acknowledge = 1;
            else ack_dly--;
        end
    end

    // Optional wait-state and external-EOP injection on the next transfer.
    bit stall_next = 0, eop_next = 0;
    int stall_cnt = 0, eop_cnt = 0;
    always @(negedge clock) begin
        if (stall_cnt > 0) begin
            stall_cnt--;
            if (stall_cnt == 0) ready = 1;
        end else if (stall_next && address_strobe) begin
            ready = 0; stall_cnt = 4; stall_next = 0;
        end
        if (eop_cnt > 0) begin
            eop_cnt--;
            if (eop_cnt == 1) end_of_process_n_in = 0;
            else if (eop_cnt == 0) end_of_process_n_in = 1;
        end else if (eop_next && address_strobe) begin
            eop_cnt = 3; eop_next = 0;
        end
    end

    // Monitor
    bit rd_d = 0, in_x = 0, hold_d = 0;
    int hold_rises = 0;
    logic [3:0]  obs_dack, obs_pat, pat;
    logic [19:0] obs_addr;
    int          obs_low;
    bit          obs_eop;
    always @(posedge clock) rd_d = reg_read;

    task automatic finish_xfer();
        xfer_t e;
        if (exp_q.size() == 0) begin
            check("xfer_unexpected_addr", {12'b0, obs_addr}, 32'hFFFFFFFF);
        end else begin
            e = exp_q.pop_front();
            check("xfer_dack", {28'b0, obs_dack}, 32'(1 << e.ch));
            check("xfer_addr", {12'b0, obs_addr}, {12'b0, e.addr});
            check("xfer_strobes", {28'b0, obs_pat}, {28'b0, e.pat});
            check("xfer_strobe_cycles", obs_low, e.low);
            check("xfer_eop", {31'b0, obs_eop}, {31'b0, e.eop});
        end
        in_x = 0;
    endtask

    always @(negedge clock) begin
        rd_t r;
        if (rd_d) begin
            if (rd_q.size() == 0) check("read_unexpected", reg_data_out, 32'hDEADBEEF);
            else begin
                r = rd_q.pop_front();
                check(r.name, reg_data_out, r.val);
            end
        end
        if (hold_request && !hold_d) hold_rises++;
        hold_d = hold_request;
        if (reset) in_x = 0;
        else begin
            if (in_x && (address_strobe || !address_enable)) finish_xfer();
            if (address_strobe) begin
                in_x = 1; obs_dack = dma_acknowledge; obs_addr = address_out;
                obs_pat = 0; obs_low = 0; obs_eop = 0;
            end else if (in_x) begin
                pat = {~memory_read_n, ~memory_write_n, ~io_read_n, ~io_write_n};
                if (pat != 0) obs_low++;
                obs_pat = obs_pat | pat;
                if (!end_of_process_n_out) obs_eop = 1;
            end
        end
    end

    task automatic wait_idle(input string name);
        int quiet, budget;
        quiet = 0; budget = 3000;
        while (quiet < 6 && budget > 0) begin
            @(negedge clock);
            budget--;
            if (exp_q.size() == 0 && !hold_request && !in_x) quiet++;
            else quiet = 0;
        end
        if (budget == 0) begin
            check(name, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic check_quiet_outputs(input string name);
        check({name, "_hold"}, {31'b0, hold_request}, 0);
        check({name, "_dack"}, {28'b0, dma_acknowledge}, 0);
        check({name, "_aen_adstb"}, {30'b0, address_enable, address_strobe}, 0);
        check({name, "_strobes"}, {27'b0, memory_read_n, memory_write_n, io_read_n, io_write_n,
                                   end_of_process_n_out}, 32'h1F);
        check({name, "_addr"}, {12'b0, address_out}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        logic [3:0] dq;
        reset = 1; reg_write = 0; reg_read = 0; reg_address = 0; reg_data_in = 0;
        dma_request = 0; ready = 1; end_of_process_n_in = 1; hold_acknowledge = 0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            m_addr[i] = 0; m_cnt[i] = 0; m_base_addr[i] = 0; m_base_cnt[i] = 0;
        end
        repeat (3) @(negedge clock);
        check_quiet_outputs("reset");
        check("reset_rdata", reg_data_out, 0);
        reset = 0;
        @(negedge clock);
        rd_gl(0, 0, "reset_command");
        rd_gl(1, 32'hF, "reset_mask");
        rd_status("reset_status");
        rd_gl(3, 0, "reset_swreq");

        // Three single transfers on ch1, IO -> memory
        wr_ch(1, 0, 32'h01000); wr_ch(1, 1, 2); wr_ch(1, 2, 32'h01);
        wr_gl(0, 1);
        dma_request = 4'b0010;
        unmask(1);
        model_run(dma_request, 2, 0);
        wait_idle("ch1_single_timeout");
        dma_request = 0;
        rd_status("ch1_status_tc");
        rd_status("ch1_status_cleared");
        rd_gl(1, {28'b0, m_mask}, "ch1_mask_set");
        rd_ch(1, 3, {15'b0, m_tc[1], m_cnt[1]}, "ch1_tc_count");
        rd_ch(1, 0, {12'b0, m_addr[1]}, "ch1_addr_after");

        // Block, decrement, address wrap on ch0
        wr_ch(0, 0, 0); wr_ch(0, 1, 1); wr_ch(0, 2, 32'h19);
        dma_request = 4'b0001;
        h0 = hold_rises;
        unmask(0);
        model_run(dma_request, 2, 0);
        wait_idle("ch0_block_timeout");
        dma_request = 0;
        check("block_hold_cycles", hold_rises - h0, 1);
        rd_ch(0, 0, {12'b0, m_addr[0]}, "ch0_addr_wrap");

        // Rotating then fixed priority between ch0 (read) and ch2 (verify)
        for (int pass = 0; pass < 2; pass++) begin
            wr_gl(0, pass == 0 ? 3 : 1);
            wr_ch(0, 0, 32'h100); wr_ch(0, 1, 3); wr_ch(0, 2, 32'h02);
            wr_ch(2, 0, 32'h200); wr_ch(2, 1, 3); wr_ch(2, 2, 32'h00);
            dma_request = 4'b0101;
            wr_gl(1, {28'b0, m_mask & 4'b1010});
            model_run(dma_request, 2, 0);
            wait_idle("priority_timeout");
            dma_request = 0;
            rd_status("priority_status");
        end

        // Wait states: ready low across S2 and two S3 cycles
        wr_gl(0, 1);
        wr_ch(3, 0, 32'h3000); wr_ch(3, 1, 0); wr_ch(3, 2, 32'h01);
        stall_next = 1;
        dma_request = 4'b1000;
        unmask(3);
        model_run(dma_request, 4, 0);
        wait_idle("stall_timeout");

        // External EOP forces early terminal count
        wr_ch(3, 0, 32'h3100); wr_ch(3, 1, 5);
        eop_next = 1;
        unmask(3);
        model_run(dma_request, 2, 1);
        wait_idle("eop_timeout");
        dma_request = 0;
        rd_ch(3, 1, {16'b0, m_cnt[3]}, "eop_count");
        rd_gl(1, {28'b0, m_mask}, "eop_mask");

        // Autoinit via software request on ch3
        wr_ch(3, 0, 32'h4000); wr_ch(3, 1, 0); wr_ch(3, 2, 32'h05);
        wr_gl(3, 32'h8);
        unmask(3);
        model_run(dma_request, 2, 0);
        wait_idle("autoinit_timeout");
        rd_ch(3, 0, {12'b0, m_addr[3]}, "autoinit_addr");
        rd_ch(3, 1, {16'b0, m_cnt[3]}, "autoinit_count");
        rd_gl(1, {28'b0, m_mask}, "autoinit_mask");
        rd_ch(3, 2, {27'b0, AI ? m_mode[3] : (m_mode[3] & 5'h1B)}, "autoinit_mode");
        rd_gl(3, {28'b0, m_sw}, "autoinit_swreq");

        // Randomised rounds: all channels, mixed modes, hardware and software requests
        for (int round = 0; round < 4; round++) begin
            wr_gl(1, 32'hF);
            for (int ch = 0; ch < 4; ch++) begin
                wr_ch(ch, 0, $urandom & 32'hFFFFF);
                wr_ch(ch, 1, $urandom_range(0, 3));
                wr_ch(ch, 2, $urandom & 32'h1B);
            end
            wr_gl(0, {30'b0, 1'($urandom_range(0, 1)), 1'b1});
            dq = 4'($urandom);
            wr_gl(3, {28'b0, 4'($urandom)});
            dma_request = dq;
            wr_gl(1, 0);
            model_run(dma_request, 2, 0);
            wait_idle("random_timeout");
            dma_request = 0;
            rd_status("random_status");
        end

        // Reset in the middle of a transfer
        wr_gl(0, 1);
        wr_ch(1, 0, 32'h5000); wr_ch(1, 1, 7); wr_ch(1, 2, 32'h01);
        dma_request = 4'b0010;
        unmask(1);
        begin
            int n;
            n = 0;
            while (io_read_n && n < 100) begin @(negedge clock); n++; end
            check("reset_test_reached_s2", {31'b0, io_read_n}, 0);
        end
        reset = 1;
        @(negedge clock);
        check_quiet_outputs("midreset");
        reset = 0;
        dma_request = 0;
        model_reset();
        @(negedge clock);
        rd_gl(1, 32'hF, "midreset_mask");
        rd_gl(0, 0, "midreset_command");
        repeat (4) @(negedge clock);

        check("leftover_reads", rd_q.size(), 0);
        check("leftover_xfers", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
